seq_fsm_q3_core: RTL and testbench
==================================

SEQ_FSM_Q3_CORE -- requirements
Module: seq_fsm_q3_core

Interface
REQ-001 Parameter: CNT_W, default 8, width of the z-entry counter.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 areset_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  qualifies x; the state advances only when this is 1.
REQ-005 x  in  1  FSM input bit, sampled when in_valid=1.
REQ-006 load  in  1  synchronous state load strobe.
REQ-007 load_state  in  3  value loaded when load=1.
REQ-008 cnt_clr  in  1  synchronous clear of z_count.
REQ-009 err_clr  in  1  synchronous clear of err.
REQ-010 y  out  3  current state register.
REQ-011 z  out  1  Moore output decoded from y.
REQ-012 z_rise  out  1  registered one-cycle pulse on entry into a z=1 state.
REQ-013 z_count  out  CNT_W  saturating count of z=1 entries.
REQ-014 err  out  1  sticky illegal-load flag.

Function
REQ-015 Legal states SHALL be 000 to 100; next state on an advance SHALL be as follows (x=0 / x=1): 000 -> 000/001; 001 -> 001/100; 010 -> 010/001; 011 -> 001/010; 100 -> 011/100.
REQ-016 The block SHALL advance y only on an edge where in_valid=1 and load=0; otherwise y SHALL hold.
REQ-017 When load=1 with load_state <= 100, y SHALL take load_state on that edge regardless of in_valid.
REQ-018 When load=1 with load_state in 101..111, y SHALL take 000 and err SHALL be set on that edge.
REQ-019 load SHALL take priority over in_valid in the same cycle.
REQ-020 If y ever holds 101..111, the next edge SHALL force y to 000 and set err, whatever in_valid and x are (load still wins).
REQ-021 z SHALL be combinational from y only: 1 for y in {011, 100}, 0 for all other values, including illegal ones.
REQ-022 z_rise SHALL be 1 for exactly the cycle after an edge where y moves from a z=0 state to a z=1 state, whether by advance or by load; otherwise it SHALL be 0.
REQ-023 z_count SHALL increment on each edge that produces z_rise, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-024 cnt_clr=1 SHALL zero z_count on that edge; a clear in the same cycle as an increment SHALL win, giving 0.
REQ-025 err_clr=1 SHALL clear err, except that a set in the same cycle SHALL win and err SHALL read 1.
REQ-026 A hold from 011 to 011 or from 100 to 100, or a move between 011 and 100, SHALL NOT produce z_rise.

Reset
REQ-027 While areset_n=0: y=000, z=0, z_rise=0, z_count=0, err=0, taking effect immediately without waiting for a clock.
REQ-028 Reset asserted mid-sequence SHALL discard state and count; the first advance after release SHALL start from 000.
REQ-029 Deassertion is synchronised outside the block; the block SHALL treat the first rising edge with areset_n=1 as normal operation.

Verification
REQ-030 Reset release, then in_valid=1 with x=1,1,1: y=001, 100, 100; z_rise=1 only after the second edge; z_count=1.
REQ-031 From y=100, x=0,1,1 with in_valid=1: y=011 (z=1, no z_rise), then 010 (z=0), then 001; z_count unchanged.
REQ-032 in_valid=0 with x toggling for 5 cycles: y, z and z_count hold.
REQ-033 load=1, load_state=110, with in_valid=1 in the same cycle: y=000, err=1; then err_clr=1: err=0; err_clr=1 together with another illegal load: err=1.
REQ-034 CNT_W=2, drive 5 entries into state 100: z_count=3; then cnt_clr=1 in the same cycle as an entry: z_count=0.
REQ-035 areset_n pulsed low between clock edges while y=100 and z_count=2: outputs reach reset values before the next edge.

Source files
------------

// File: rtl/seq_fsm_q3_core.sv
// seq_fsm_q3_core: five-state sequence FSM with state load, z-entry pulse,
// saturating entry counter and sticky illegal-load/illegal-state flag.
module seq_fsm_q3_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             in_valid,
  input  logic             x,
  input  logic             load,
  input  logic [2:0]       load_state,
  input  logic             cnt_clr,
  input  logic             err_clr,
  output logic [2:0]       y,
  output logic             z,
  output logic             z_rise,
  output logic [CNT_W-1:0] z_count,
  output logic             err
);
  logic [2:0]       r_y, w_y_nxt, w_adv;
  logic             r_z_rise, r_err;
  logic [CNT_W-1:0] r_cnt;
  logic             w_bad_load, w_bad_state, w_err_set, w_z_nxt, w_rise;

  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) r_y <= 3'd0;
    else           r_y <= w_y_nxt;

  always_comb begin
    w_adv = 3'd0;
    case (r_y)
      3'd0:    w_adv = x ? 3'd1 : 3'd0;
      3'd1:    w_adv = x ? 3'd4 : 3'd1;
      3'd2:    w_adv = x ? 3'd1 : 3'd2;
      3'd3:    w_adv = x ? 3'd2 : 3'd1;
      3'd4:    w_adv = x ? 3'd4 : 3'd3;
      default: w_adv = 3'd0;
    endcase
    w_bad_load  = load && load_state > 3'd4;
    w_bad_state = !load && r_y > 3'd4;
    w_y_nxt     = load ? (w_bad_load ? 3'd0 : load_state) :
                  w_bad_state ? 3'd0 : in_valid ? w_adv : r_y;
  end

  // z is decoded from the current state; the pulse looks one edge ahead
  always_comb begin
    z         = r_y == 3'd3 || r_y == 3'd4;
    w_z_nxt   = w_y_nxt == 3'd3 || w_y_nxt == 3'd4;
    w_rise    = !z && w_z_nxt;
    w_err_set = w_bad_load || w_bad_state;
  end

  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      r_z_rise <= 1'b0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_z_rise <= w_rise;
      r_cnt    <= cnt_clr ? '0 : (w_rise && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
      r_err    <= w_err_set ? 1'b1 : err_clr ? 1'b0 : r_err;
    end

  assign y       = r_y;
  assign z_rise  = r_z_rise;
  assign z_count = r_cnt;
  assign err     = r_err;
endmodule

// File: tb/tb_seq_fsm_q3_core.sv
// tb_seq_fsm_q3_core: directed table-driven bench; a default-width and a
// 2-bit-counter instance share stimulus so saturation is visible side by side.
module tb_seq_fsm_q3_core;
  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       in_valid = 1'b0, x = 1'b0, load = 1'b0, cnt_clr = 1'b0, err_clr = 1'b0;
  logic [2:0] load_state = 3'd0;
  logic [2:0] y8, y2;
  logic       z8, z2, zr8, zr2, e8, e2;
  logic [7:0] c8;
  logic [1:0] c2;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  seq_fsm_q3_core u8 (
    .clk(clk), .areset_n(areset_n), .in_valid(in_valid), .x(x), .load(load),
    .load_state(load_state), .cnt_clr(cnt_clr), .err_clr(err_clr),
    .y(y8), .z(z8), .z_rise(zr8), .z_count(c8), .err(e8));

  seq_fsm_q3_core #(.CNT_W(2)) u2 (
    .clk(clk), .areset_n(areset_n), .in_valid(in_valid), .x(x), .load(load),
    .load_state(load_state), .cnt_clr(cnt_clr), .err_clr(err_clr),
    .y(y2), .z(z2), .z_rise(zr2), .z_count(c2), .err(e2));

  typedef struct {
    logic       ld;
    logic [2:0] ls;
    logic       v, xi, cc, ec;
    logic [2:0] ey;
    logic       ez, er;
    logic [7:0] ec8;
    logic       ee;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] ey, input logic ez,
                           input logic er, input logic [7:0] ec, input logic ee);
    logic [1:0] ec2;
    ec2 = ec > 8'd3 ? 2'd3 : ec[1:0];
    chk({tag, ".y"}, {5'd0, y8}, {5'd0, ey});
    chk({tag, ".z"}, {7'd0, z8}, {7'd0, ez});
    chk({tag, ".z_rise"}, {7'd0, zr8}, {7'd0, er});
    chk({tag, ".z_count"}, c8, ec);
    chk({tag, ".err"}, {7'd0, e8}, {7'd0, ee});
    chk({tag, ".y2"}, {5'd0, y2}, {5'd0, ey});
    chk({tag, ".z_count2"}, {6'd0, c2}, {6'd0, ec2});
    chk({tag, ".z_rise2"}, {7'd0, zr2}, {7'd0, er});
  endtask

  task automatic drive(input logic ld, input logic [2:0] ls, input logic v,
                       input logic xi, input logic cc, input logic ec);
    load = ld; load_state = ls; in_valid = v; x = xi; cnt_clr = cc; err_clr = ec;
    @(posedge clk);
    #1;
  endtask

  vec_t tv[$];

  initial begin
    //        ld  ls    v  x  cc ec   y     z  r  cnt  err
    tv.push_back('{0, 3'd0, 1, 1, 0, 0, 3'd1, 0, 0, 8'd0, 0});
    tv.push_back('{0, 3'd0, 1, 1, 0, 0, 3'd4, 1, 1, 8'd1, 0});
    tv.push_back('{0, 3'd0, 1, 1, 0, 0, 3'd4, 1, 0, 8'd1, 0});
    tv.push_back('{0, 3'd0, 1, 0, 0, 0, 3'd3, 1, 0, 8'd1, 0});
    tv.push_back('{0, 3'd0, 1, 1, 0, 0, 3'd2, 0, 0, 8'd1, 0});
    tv.push_back('{0, 3'd0, 1, 1, 0, 0, 3'd1, 0, 0, 8'd1, 0});
    tv.push_back('{0, 3'd0, 0, 0, 0, 0, 3'd1, 0, 0, 8'd1, 0});
    tv.push_back('{0, 3'd0, 0, 1, 0, 0, 3'd1, 0, 0, 8'd1, 0});
    tv.push_back('{0, 3'd0, 0, 0, 0, 0, 3'd1, 0, 0, 8'd1, 0});
    tv.push_back('{0, 3'd0, 0, 1, 0, 0, 3'd1, 0, 0, 8'd1, 0});
    tv.push_back('{0, 3'd0, 0, 0, 0, 0, 3'd1, 0, 0, 8'd1, 0});
    tv.push_back('{1, 3'd6, 1, 1, 0, 0, 3'd0, 0, 0, 8'd1, 1});
    tv.push_back('{0, 3'd0, 0, 0, 0, 1, 3'd0, 0, 0, 8'd1, 0});
    tv.push_back('{1, 3'd7, 0, 0, 0, 1, 3'd0, 0, 0, 8'd1, 1});
    tv.push_back('{0, 3'd0, 0, 0, 0, 1, 3'd0, 0, 0, 8'd1, 0});
    tv.push_back('{1, 3'd3, 0, 0, 0, 0, 3'd3, 1, 1, 8'd2, 0});
    tv.push_back('{1, 3'd4, 0, 0, 0, 0, 3'd4, 1, 0, 8'd2, 0});
    tv.push_back('{0, 3'd0, 1, 0, 0, 0, 3'd3, 1, 0, 8'd2, 0});
    tv.push_back('{1, 3'd2, 0, 0, 0, 0, 3'd2, 0, 0, 8'd2, 0});
    tv.push_back('{0, 3'd0, 1, 1, 0, 0, 3'd1, 0, 0, 8'd2, 0});
    tv.push_back('{0, 3'd0, 1, 1, 0, 0, 3'd4, 1, 1, 8'd3, 0});
    tv.push_back('{1, 3'd0, 1, 1, 0, 0, 3'd0, 0, 0, 8'd3, 0});
    tv.push_back('{0, 3'd0, 1, 0, 0, 0, 3'd0, 0, 0, 8'd3, 0});
    tv.push_back('{1, 3'd4, 0, 0, 0, 0, 3'd4, 1, 1, 8'd4, 0});
    tv.push_back('{0, 3'd0, 1, 1, 0, 0, 3'd4, 1, 0, 8'd4, 0});
    tv.push_back('{1, 3'd1, 0, 0, 0, 0, 3'd1, 0, 0, 8'd4, 0});
    tv.push_back('{0, 3'd0, 1, 1, 0, 0, 3'd4, 1, 1, 8'd5, 0});
    tv.push_back('{1, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 8'd5, 0});
    tv.push_back('{1, 3'd3, 0, 0, 1, 0, 3'd3, 1, 1, 8'd0, 0});
    tv.push_back('{0, 3'd0, 0, 0, 1, 0, 3'd3, 1, 0, 8'd0, 0});
    tv.push_back('{0, 3'd0, 1, 1, 0, 0, 3'd2, 0, 0, 8'd0, 0});
    tv.push_back('{0, 3'd0, 1, 0, 0, 0, 3'd2, 0, 0, 8'd0, 0});
    tv.push_back('{1, 3'd3, 0, 0, 0, 0, 3'd3, 1, 1, 8'd1, 0});
    tv.push_back('{0, 3'd0, 1, 0, 0, 0, 3'd1, 0, 0, 8'd1, 0});
    tv.push_back('{0, 3'd0, 1, 0, 0, 0, 3'd1, 0, 0, 8'd1, 0});
    tv.push_back('{1, 3'd0, 0, 0, 0, 0, 3'd0, 0, 0, 8'd1, 0});
    tv.push_back('{1, 3'd4, 0, 0, 0, 0, 3'd4, 1, 1, 8'd2, 0});

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3'd0, 0, 0, 8'd0, 0);
    areset_n = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].ld, tv[i].ls, tv[i].v, tv[i].xi, tv[i].cc, tv[i].ec);
      check_all($sformatf("vec%0d", i), tv[i].ey, tv[i].ez, tv[i].er, tv[i].ec8, tv[i].ee);
    end

    // asynchronous reset between edges with y=100, z_count=2
    load = 1'b0; in_valid = 1'b0;
    #2 areset_n = 1'b0;
    #1 check_all("async_rst", 3'd0, 0, 0, 8'd0, 0);
    @(posedge clk);
    #1 check_all("rst_held", 3'd0, 0, 0, 8'd0, 0);
    areset_n = 1'b1;
    drive(0, 3'd0, 1, 1, 0, 0);
    check_all("post_rst_adv", 3'd1, 0, 0, 8'd0, 0);
    drive(0, 3'd0, 1, 1, 0, 0);
    check_all("post_rst_entry", 3'd4, 1, 1, 8'd1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
